// File: rtl/sample_fifo_pkg.sv
// Package: sample_fifo_pkg
// Purpose: shared defaults and types for the tagged-sample FIFO.
//   DEF_DATA_W  default word width
//   DEF_DEPTH   default storage depth (power of two, >= 4)
//   DEF_ADDR_W  log2(DEF_DEPTH)
//   sample_t    one tagged sample {idx[2:0], data[12:0]}
package sample_fifo_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_DEPTH  = 1024;
   localparam int DEF_ADDR_W = 10;

   typedef struct packed {
      logic [2:0]  idx;
      logic [12:0] data;
   } sample_t;

endpackage

// File: rtl/sample_fifo_core_if.sv
// Interface: sample_fifo_core_if
// Purpose: bundles the push/pop request lines, read data and status flags of the FIFO.
//   din, wr_en     push side (collector -> FIFO)
//   rd_en          pop request (host readout -> FIFO)
//   dout, valid    registered read data and its qualifier
//   full, almost_full, empty, almost_empty   registered occupancy flags
//   wr_ack, overflow, underflow              single-cycle result strobes
//
// Handshake: a push is taken on a rising edge when wr_en is high and full is low,
// and is reported one cycle later by wr_ack (or overflow if full was high). A pop is
// taken on a rising edge when rd_en is high and empty is low; dout and valid update
// on that same edge (valid high for exactly one cycle per accepted pop), and a
// refused pop pulses underflow and leaves dout untouched. There is no back-pressure
// beyond the flags: the requester is expected to watch full/empty itself.
interface sample_fifo_core_if #(
   parameter int DATA_W = sample_fifo_pkg::DEF_DATA_W
);
   logic [DATA_W-1:0] din;
   logic              wr_en;
   logic              rd_en;
   logic [DATA_W-1:0] dout;
   logic              full;
   logic              almost_full;
   logic              wr_ack;
   logic              overflow;
   logic              underflow;
   logic              empty;
   logic              almost_empty;
   logic              valid;

   modport master (
      output din, wr_en, rd_en,
      input  dout, full, almost_full, wr_ack, overflow, underflow,
             empty, almost_empty, valid
   );

   modport slave (
      input  din, wr_en, rd_en,
      output dout, full, almost_full, wr_ack, overflow, underflow,
             empty, almost_empty, valid
   );
endinterface

// File: rtl/sample_fifo_ram.sv
// Module: sample_fifo_ram
// Purpose: simple dual-port storage, one write port and one registered read port,
//          written so synthesis maps it onto block RAM.
//   clk, rst     clock and synchronous reset (reset clears only the read register)
//   we, waddr, wdata   write port
//   re, raddr          read enable and address; rdata loads only when re is high
//   rdata        registered read data
module sample_fifo_ram #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   // Storage is never reset so it stays a plain RAM array.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // The output register holds its value when re is low, which is how a refused
   // read leaves the previous word on dout. The controller never reads and writes
   // the same address in one cycle, so read-during-write behaviour does not matter.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/sample_fifo_core.sv
// Module: sample_fifo_core
// Purpose: single-clock FIFO for 16-bit tagged samples, standard (non-FWFT) read.
//   clk   rising-edge clock
//   rst   synchronous active-high reset; discards all stored words
//   bus   sample_fifo_core_if.slave: din/wr_en push, rd_en pop, dout/valid read
//         data, full/almost_full/empty/almost_empty flags, wr_ack/overflow/underflow
// Pointers, occupancy count, flags and strobes live here; storage is sample_fifo_ram.
module sample_fifo_core
   import sample_fifo_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = DEF_ADDR_W   // must equal log2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   sample_fifo_core_if.slave   bus
);

   localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_AFULL = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

   logic [ADDR_W-1:0] wr_ptr_q;
   logic [ADDR_W-1:0] rd_ptr_q;
   logic [ADDR_W:0]   count_q;
   logic [ADDR_W:0]   count_nxt;

   logic full_q, almost_full_q, empty_q, almost_empty_q;
   logic wr_ack_q, overflow_q, underflow_q, valid_q;

   logic wr_acc;
   logic rd_acc;

   // Acceptance uses the registered flags only, so a full FIFO refuses a write even
   // when a read frees a slot in the same cycle, and an empty FIFO never bypasses.
   assign wr_acc = bus.wr_en && !full_q;
   assign rd_acc = bus.rd_en && !empty_q;

   always_comb begin
      count_nxt = count_q;
      unique case ({wr_acc, rd_acc})
         2'b10:   count_nxt = count_q + CNT_ONE;
         2'b01:   count_nxt = count_q - CNT_ONE;
         default: count_nxt = count_q;
      endcase
   end

   // Flags are derived from the next count, so they are already correct in the
   // cycle right after the operation that changed occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         full_q         <= 1'b0;
         almost_full_q  <= 1'b0;
         empty_q        <= 1'b1;
         almost_empty_q <= 1'b1;
         wr_ack_q       <= 1'b0;
         overflow_q     <= 1'b0;
         underflow_q    <= 1'b0;
         valid_q        <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (rd_acc) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         count_q        <= count_nxt;
         full_q         <= (count_nxt == CNT_FULL);
         almost_full_q  <= (count_nxt >= CNT_AFULL);
         empty_q        <= (count_nxt == '0);
         almost_empty_q <= (count_nxt <= CNT_ONE);
         wr_ack_q       <= wr_acc;
         overflow_q     <= bus.wr_en && full_q;
         underflow_q    <= bus.rd_en && empty_q;
         valid_q        <= rd_acc;
      end
   end

   sample_fifo_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_acc),
      .waddr (wr_ptr_q),
      .wdata (bus.din),
      .re    (rd_acc),
      .raddr (rd_ptr_q),
      .rdata (bus.dout)
   );

   assign bus.full         = full_q;
   assign bus.almost_full  = almost_full_q;
   assign bus.empty        = empty_q;
   assign bus.almost_empty = almost_empty_q;
   assign bus.wr_ack       = wr_ack_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;
   assign bus.valid        = valid_q;

endmodule

// File: tb/tb_sample_fifo_core.sv
// Testbench for sample_fifo_core: a queue-based reference model tracks what the
// FIFO should hold and what each output should show after every clock edge.
module tb_sample_fifo_core;
   import sample_fifo_pkg::*;

   localparam int DEPTH = 1024;
   localparam int W     = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sample_fifo_core_if #(.DATA_W(W)) bus ();

   sample_fifo_core dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- scoreboard / reference model ----------------
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_dout;
   logic         exp_valid, exp_wr_ack, exp_overflow, exp_underflow;

   int checks = 0;
   int errors = 0;

   // {full, almost_full, empty, almost_empty} expected from the model's occupancy
   function automatic logic [3:0] exp_flags();
      int n;
      n = exp_q.size();
      return {n == DEPTH, n >= DEPTH - 1, n == 0, n <= 1};
   endfunction

   function automatic logic [3:0] dut_flags();
      return {bus.full, bus.almost_full, bus.empty, bus.almost_empty};
   endfunction

   function automatic logic [W+7:0] exp_vec();
      return {exp_dout, exp_valid, exp_wr_ack, exp_overflow, exp_underflow, exp_flags()};
   endfunction

   function automatic logic [W+7:0] dut_vec();
      return {bus.dout, bus.valid, bus.wr_ack, bus.overflow, bus.underflow, dut_flags()};
   endfunction

   function automatic logic [W-1:0] rand_sample();
      sample_t s;
      s.idx  = 3'($urandom_range(7));
      s.data = 13'($urandom_range(8191));
      return s;
   endfunction

   // ---------------- driver ----------------
   // Drives one clock of requests, then advances the model to match the edge.
   // On return we are 1 time unit after the edge with inputs idle.
   task automatic cycle(input logic wr, input logic rd, input logic [W-1:0] d,
                        input logic r);
      logic was_full, was_empty;
      bus.wr_en = wr;
      bus.rd_en = rd;
      bus.din   = d;
      rst       = r;
      @(posedge clk);
      if (r) begin
         exp_q.delete();
         exp_dout      = '0;
         exp_valid     = 1'b0;
         exp_wr_ack    = 1'b0;
         exp_overflow  = 1'b0;
         exp_underflow = 1'b0;
      end else begin
         was_full      = (exp_q.size() == DEPTH);
         was_empty     = (exp_q.size() == 0);
         exp_wr_ack    = wr && !was_full;
         exp_overflow  = wr && was_full;
         exp_underflow = rd && was_empty;
         exp_valid     = rd && !was_empty;
         if (exp_valid)  exp_dout = exp_q.pop_front();
         if (exp_wr_ack) exp_q.push_back(d);
      end
      #1;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      rst       = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      cycle(1'b0, 1'b0, '0, 1'b1);
      cycle(1'b1, 1'b1, 16'h1234, 1'b1);
      checks++;
      if (dut_flags() !== 4'b0011) begin
         errors++;
         $display("FAIL reset_flags: got %b expected %b", dut_flags(), 4'b0011);
      end
      checks++;
      if ({bus.valid, bus.wr_ack, bus.overflow, bus.underflow} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_strobes: got %b expected 0000",
                  {bus.valid, bus.wr_ack, bus.overflow, bus.underflow});
      end
      checks++;
      if (bus.dout !== 16'h0000) begin
         errors++;
         $display("FAIL reset_dout: got %h expected 0000", bus.dout);
      end
   endtask

   task automatic test_basic();
      logic [W-1:0] words [3];
      words[0] = 16'hA001;
      words[1] = 16'hA002;
      words[2] = 16'hA003;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b0, words[i], 1'b0);
         checks++;
         if (bus.wr_ack !== 1'b1 || bus.empty !== 1'b0) begin
            errors++;
            $display("FAIL basic_write%0d: wr_ack=%b empty=%b expected 1/0", i, bus.wr_ack, bus.empty);
         end
      end
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b1, '0, 1'b0);
         checks++;
         if (bus.dout !== words[i] || bus.valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_read%0d: dout=%h valid=%b expected %h/1", i, bus.dout, bus.valid, words[i]);
         end
      end
      checks++;
      if (bus.empty !== 1'b1 || bus.almost_empty !== 1'b1) begin
         errors++;
         $display("FAIL basic_empty: empty=%b almost_empty=%b expected 1/1", bus.empty, bus.almost_empty);
      end
   endtask

   task automatic test_fill();
      cycle(1'b0, 1'b0, '0, 1'b1);
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1'b1, 1'b0, W'(i), 1'b0);
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL fill_step%0d: got %h expected %h", i, dut_vec(), exp_vec());
         end
         if (i == DEPTH - 2) begin
            checks++;
            if (bus.almost_full !== 1'b1 || bus.full !== 1'b0) begin
               errors++;
               $display("FAIL fill_almost_full: af=%b full=%b expected 1/0", bus.almost_full, bus.full);
            end
         end
      end
      checks++;
      if (bus.full !== 1'b1) begin
         errors++;
         $display("FAIL fill_full: got %b expected 1", bus.full);
      end
      cycle(1'b1, 1'b0, 16'hFFFF, 1'b0);
      checks++;
      if (bus.overflow !== 1'b1 || bus.wr_ack !== 1'b0 || bus.full !== 1'b1) begin
         errors++;
         $display("FAIL fill_overflow: ovf=%b ack=%b full=%b expected 1/0/1",
                  bus.overflow, bus.wr_ack, bus.full);
      end
      cycle(1'b0, 1'b0, '0, 1'b0);
      checks++;
      if (bus.overflow !== 1'b0) begin
         errors++;
         $display("FAIL fill_overflow_pulse: got %b expected 0", bus.overflow);
      end
      // contents must be exactly 0..DEPTH-1, independent of the model queue
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1'b0, 1'b1, '0, 1'b0);
         checks++;
         if (bus.dout !== W'(i) || bus.valid !== 1'b1 || dut_flags() !== exp_flags()) begin
            errors++;
            $display("FAIL fill_drain%0d: dout=%h valid=%b flags=%b expected %h/1/%b",
                     i, bus.dout, bus.valid, dut_flags(), W'(i), exp_flags());
         end
      end
   endtask

   task automatic test_underflow();
      // FIFO is empty here and the last word read out was DEPTH-1
      cycle(1'b0, 1'b1, '0, 1'b0);
      checks++;
      if (bus.underflow !== 1'b1 || bus.valid !== 1'b0 || bus.dout !== W'(DEPTH - 1)) begin
         errors++;
         $display("FAIL underflow_read: unf=%b valid=%b dout=%h expected 1/0/%h",
                  bus.underflow, bus.valid, bus.dout, W'(DEPTH - 1));
      end
      cycle(1'b0, 1'b0, '0, 1'b0);
      checks++;
      if (bus.underflow !== 1'b0) begin
         errors++;
         $display("FAIL underflow_pulse: got %b expected 0", bus.underflow);
      end
      // write + read into an empty FIFO: write lands, read is refused
      cycle(1'b1, 1'b1, 16'h5A5A, 1'b0);
      checks++;
      if ({bus.underflow, bus.wr_ack, bus.valid, bus.empty} !== 4'b1100) begin
         errors++;
         $display("FAIL underflow_no_bypass: unf/ack/valid/empty=%b expected 1100",
                  {bus.underflow, bus.wr_ack, bus.valid, bus.empty});
      end
      cycle(1'b0, 1'b1, '0, 1'b0);
      checks++;
      if (bus.dout !== 16'h5A5A || bus.valid !== 1'b1) begin
         errors++;
         $display("FAIL underflow_followup: dout=%h valid=%b expected 5a5a/1", bus.dout, bus.valid);
      end
   endtask

   task automatic test_simul_wrap();
      cycle(1'b0, 1'b0, '0, 1'b1);
      // walk both pointers close to the wrap point at occupancy 1
      cycle(1'b1, 1'b0, rand_sample(), 1'b0);
      for (int i = 0; i < 1000; i++) cycle(1'b1, 1'b1, rand_sample(), 1'b0);
      cycle(1'b0, 1'b1, '0, 1'b0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL simul_prewalk: got %h expected %h", dut_vec(), exp_vec());
      end
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, rand_sample(), 1'b0);
      for (int i = 0; i < 100; i++) begin
         cycle(1'b1, 1'b1, rand_sample(), 1'b0);
         checks++;
         if (dut_vec() !== exp_vec() || dut_flags() !== 4'b0000) begin
            errors++;
            $display("FAIL simul_step%0d: got %h expected %h", i, dut_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         cycle(1'($urandom_range(1)), 1'($urandom_range(1)), rand_sample(), 1'b0);
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL random_step%0d: got %h expected %h", i, dut_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_reset_mid();
      cycle(1'b0, 1'b0, '0, 1'b1);
      for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, rand_sample(), 1'b0);
      cycle(1'b1, 1'b1, rand_sample(), 1'b1);
      checks++;
      if ({dut_flags(), bus.valid, bus.wr_ack, bus.dout} !== {4'b0011, 2'b00, 16'h0000}) begin
         errors++;
         $display("FAIL reset_mid_state: flags=%b valid=%b ack=%b dout=%h expected 0011/0/0/0000",
                  dut_flags(), bus.valid, bus.wr_ack, bus.dout);
      end
      cycle(1'b0, 1'b1, '0, 1'b0);
      checks++;
      if (bus.underflow !== 1'b1 || bus.valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_underflow: unf=%b valid=%b expected 1/0", bus.underflow, bus.valid);
      end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      bus.din   = '0;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      exp_dout  = '0;
      exp_valid = 1'b0; exp_wr_ack = 1'b0; exp_overflow = 1'b0; exp_underflow = 1'b0;
      test_reset();
      test_basic();
      test_fill();
      test_underflow();
      test_simul_wrap();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
